// File: rtl/intdiv_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration counter width helper.
package intdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LOGA_DEFAULT = 60;
  localparam int LOGB_DEFAULT = 60;

  // The counter must hold the value LOGA itself, hence LOGA+1 states.
  function automatic int cnt_width(input int loga);
    return $clog2(loga + 1);
  endfunction

endpackage

// File: rtl/intdiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and produce one quotient bit.
module intdiv_step #(
  parameter int LOGB = 60
) (
  input  logic [LOGB:0]   p_i,
  input  logic            c_bit_i,
  input  logic [LOGB-1:0] b_i,
  output logic [LOGB:0]   p_o,
  output logic            q_bit_o
);

  logic [LOGB+1:0] t_wide;
  logic [LOGB:0]   t;
  logic            t_ge_b;

  // The partial remainder is always below B, so its top bit is zero; keeping
  // it in the compare makes the step correct for any P without extra cost.
  always_comb begin
    t_wide  = {p_i, c_bit_i};
    t       = t_wide[LOGB:0];
    t_ge_b  = (t_wide >= {2'b00, b_i});
    q_bit_o = t_ge_b;
    p_o     = t_ge_b ? (t - {1'b0, b_i}) : t;
  end

endmodule

// File: rtl/intdiv_seq.sv
// Sequential unsigned divider: (LOGA+LOGB)-bit dividend by LOGB-bit divisor,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow flags.
module intdiv_seq
  import intdiv_pkg::*;
#(
  parameter int LOGA = LOGA_DEFAULT,
  parameter int LOGB = LOGB_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOGA+LOGB-1:0] C,
  input  logic [LOGB-1:0]      B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOGA-1:0]      Q,
  output logic [LOGB-1:0]      R,
  output logic                 dbz,
  output logic                 ovf
);

  localparam int CW = cnt_width(LOGA);

  state_e          state_q, state_d;
  logic [LOGA-1:0] c_lo_q, c_lo_d;
  logic [LOGB-1:0] b_q, b_d;
  logic [LOGB:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LOGA-1:0] q_q, q_d;
  logic [LOGB-1:0] r_q, r_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic [LOGB-1:0] c_hi;
  logic [LOGB:0]   step_p;
  logic            step_q_bit;

  assign c_hi = C[LOGA+LOGB-1:LOGA];

  intdiv_step #(
    .LOGB (LOGB)
  ) u_step (
    .p_i     (p_q),
    .c_bit_i (c_lo_q[LOGA-1]),
    .b_i     (b_q),
    .p_o     (step_p),
    .q_bit_o (step_q_bit)
  );

  always_comb begin
    state_d = state_q;
    c_lo_d  = c_lo_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          b_d    = B;
          c_lo_d = C[LOGA-1:0];
          q_d    = '0;
          r_d    = '0;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          // Zero divisor is checked first so dbz wins when both conditions hold.
          if (B == '0) begin
            q_d     = '1;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else if (c_hi >= B) begin
            q_d     = '1;
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            p_d     = {1'b0, c_hi};
            cnt_d   = CW'(LOGA);
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        p_d    = step_p;
        q_d    = LOGA'({q_q, step_q_bit});
        c_lo_d = c_lo_q << 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          r_d     = step_p[LOGB-1:0];
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      c_lo_q  <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_lo_q  <= c_lo_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_intdiv_seq.sv
// Directed-vector bench for intdiv_seq at LOGA=LOGB=60: results, flags,
// latency, back-pressure hold, idle input noise and asynchronous abort.
module tb_intdiv_seq;

  localparam int LOGA = 60;
  localparam int LOGB = 60;
  localparam logic [59:0] ONES = {60{1'b1}};

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_valid;
  logic           in_ready;
  logic [119:0]   c_in;
  logic [59:0]    b_in;
  logic           out_valid;
  logic           out_ready;
  logic [59:0]    q_out;
  logic [59:0]    r_out;
  logic           dbz;
  logic           ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intdiv_seq #(
    .LOGA (LOGA),
    .LOGB (LOGB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C         (c_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (q_out),
    .R         (r_out),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ":in_ready"}, 128'(in_ready), 128'(1));
    checkOutput({tag, ":out_valid"}, 128'(out_valid), 128'(0));
    checkOutput({tag, ":Q"}, 128'(q_out), 128'(0));
    checkOutput({tag, ":R"}, 128'(r_out), 128'(0));
    checkOutput({tag, ":dbz"}, 128'(dbz), 128'(0));
    checkOutput({tag, ":ovf"}, 128'(ovf), 128'(0));
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic acceptOperands(input logic [119:0] c, input logic [59:0] b);
    int waited = 0;
    while (!in_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    c_in     = c;
    b_in     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c_in     = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
    b_in     = 60'({$urandom(), $urandom()});
  endtask

  task automatic applyStimulus(input string tag, input logic [119:0] c, input logic [59:0] b,
                               input logic [59:0] exp_q, input logic [59:0] exp_r,
                               input logic exp_dbz, input logic exp_ovf,
                               input int exp_lat, input int hold);
    int cycles = 0;
    acceptOperands(c, b);
    while (cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1 && exp_lat > 1)
        checkOutput({tag, ":busy_in_ready"}, 128'(in_ready), 128'(0));
      if (out_valid) break;
    end
    checkOutput({tag, ":latency"}, 128'(cycles), 128'(exp_lat));
    checkOutput({tag, ":Q"}, 128'(q_out), 128'(exp_q));
    checkOutput({tag, ":R"}, 128'(r_out), 128'(exp_r));
    checkOutput({tag, ":dbz"}, 128'(dbz), 128'(exp_dbz));
    checkOutput({tag, ":ovf"}, 128'(ovf), 128'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, ":hold_valid"}, 128'(out_valid), 128'(1));
      checkOutput({tag, ":hold_in_ready"}, 128'(in_ready), 128'(0));
      checkOutput({tag, ":hold_Q"}, 128'(q_out), 128'(exp_q));
      checkOutput({tag, ":hold_R"}, 128'(r_out), 128'(exp_r));
      checkOutput({tag, ":hold_flags"}, 128'({dbz, ovf}), 128'({exp_dbz, exp_ovf}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, ":drain_valid"}, 128'(out_valid), 128'(0));
    checkOutput({tag, ":drain_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [119:0] big_c;
    big_c = ((120'd1 << 60) - 120'd1) * ((120'd1 << 60) - 120'd1);

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    c_in      = '0;
    b_in      = '0;
    #12;
    checkResetValues("reset");
    rstn = 1'b1;

    applyStimulus("max_q", big_c, ONES, ONES, 60'd0, 1'b0, 1'b0, 60, 0);
    applyStimulus("c1000_b7", 120'd1000, 60'd7, 60'd142, 60'd6, 1'b0, 1'b0, 60, 0);
    applyStimulus("dbz", 120'd5, 60'd0, ONES, 60'd0, 1'b1, 1'b0, 1, 0);
    applyStimulus("ovf", 120'd1 << 60, 60'd1, ONES, 60'd0, 1'b0, 1'b1, 1, 0);
    applyStimulus("hold5", 120'd1000, 60'd7, 60'd142, 60'd6, 1'b0, 1'b0, 60, 5);
    applyStimulus("dbz_prio", 120'd1 << 100, 60'd0, ONES, 60'd0, 1'b1, 1'b0, 1, 0);
    applyStimulus("ovf_equal", {120{1'b1}}, ONES, ONES, 60'd0, 1'b0, 1'b1, 1, 0);
    applyStimulus("hi_just_below", (120'd3 << 60) - 120'd1, 60'd3, ONES, 60'd2, 1'b0, 1'b0, 60, 0);
    applyStimulus("zero_dividend", 120'd0, 60'd5, 60'd0, 60'd0, 1'b0, 1'b0, 60, 0);
    applyStimulus("equal", 120'(ONES), ONES, 60'd1, 60'd0, 1'b0, 1'b0, 60, 0);

    // Noise on the inputs without in_valid must leave the block idle.
    c_in = 120'd77;
    b_in = 60'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_noise", 128'({in_ready, out_valid}), 128'(2'b10));

    // Abort in the 30th CALC cycle, then a fresh operation must work.
    acceptOperands(big_c, ONES);
    repeat (29) @(posedge clk);
    #3;
    checkOutput("abort:busy", 128'(in_ready), 128'(0));
    #1 rstn = 1'b0;
    #1;
    checkResetValues("abort_async");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort:no_result", 128'({in_ready, out_valid}), 128'(2'b10));
    applyStimulus("after_abort", 120'd21, 60'd4, 60'd5, 60'd1, 1'b0, 1'b0, 60, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
